// File: rtl/seq_sub_64_if.sv
// ---------------------------------------------------------------------------
// seq_sub_64_if
//   Request/result bundle for the multi-cycle 64-bit subtractor.
//
//   Request side (driven by the controller):
//     start  - accept request, sampled on the rising clock edge
//     a      - 64-bit minuend
//     b      - 64-bit subtrahend
//     bin    - borrow-in
//   Result side (driven by the subtractor, all registered):
//     d      - 64-bit difference
//     bout   - borrow-out, 1 iff a < b + bin (unsigned)
//     ovf    - signed overflow of a - b - bin
//     busy   - slices are being computed
//     done   - one-cycle pulse, d/bout/ovf valid
//
//   Modports:
//     master - the controller issuing subtractions
//     slave  - the subtractor itself
// ---------------------------------------------------------------------------
interface seq_sub_64_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output a,
        output b,
        output bin,
        input  d,
        input  bout,
        input  ovf,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
        output d,
        output bout,
        output ovf,
        output busy,
        output done
    );
endinterface

// File: rtl/seq_sub_64.sv
// ---------------------------------------------------------------------------
// seq_sub_64
//   Multi-cycle 64-bit subtractor: d = a - b - bin, computed one 16-bit slice
//   per clock (least significant slice first) with a registered borrow
//   carried from slice to slice. Operands are captured only on the edge that
//   accepts start; later changes on the inputs do not affect the operation.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset; aborts any operation in flight
//     bus  - seq_sub_64_if.slave: start/a/b/bin in, d/bout/ovf/busy/done out
//
//   Timing (start accepted at edge k):
//     busy = 1 after edges k..k+3, slices 0..3 written at edges k+1..k+4,
//     done = 1 for exactly one cycle after edge k+4. A start seen in the
//     done cycle is accepted immediately, giving a 5-cycle issue interval.
// ---------------------------------------------------------------------------
module seq_sub_64 (
    input  logic          clk,
    input  logic          rst,
    seq_sub_64_if.slave   bus
);

    localparam int WIDTH    = 64;
    localparam int SLICE_W  = 16;
    localparam int N_SLICES = WIDTH / SLICE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_reg,  state_next;
    logic [1:0]         cnt_reg,    cnt_next;
    logic [WIDTH-1:0]   a_reg,      a_next;
    logic [WIDTH-1:0]   b_reg,      b_next;
    logic               borrow_reg, borrow_next;
    logic [WIDTH-1:0]   d_reg,      d_next;
    logic               bout_reg,   bout_next;
    logic               ovf_reg,    ovf_next;
    logic               busy_reg,   busy_next;
    logic               done_reg,   done_next;

    // -----------------------------------------------------------------------
    // Slice views of the latched operands
    // -----------------------------------------------------------------------
    logic [SLICE_W-1:0] a_slice [N_SLICES];
    logic [SLICE_W-1:0] b_slice [N_SLICES];

    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice_view
        assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
        assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end

    // -----------------------------------------------------------------------
    // One 16-bit slice subtractor, shared across all four cycles.
    // The extra top bit of the 17-bit difference is the slice borrow-out:
    // it is set exactly when the slice result went below zero.
    // -----------------------------------------------------------------------
    logic [SLICE_W-1:0] a_cur;
    logic [SLICE_W-1:0] b_cur;
    logic [SLICE_W:0]   slice_diff;
    logic               slice_borrow;

    assign a_cur        = a_slice[cnt_reg];
    assign b_cur        = b_slice[cnt_reg];
    assign slice_diff   = {1'b0, a_cur} - {1'b0, b_cur} - {{SLICE_W{1'b0}}, borrow_reg};
    assign slice_borrow = slice_diff[SLICE_W];

    // A request is taken only from IDLE or DONE; start during RUN is ignored.
    logic accept;
    logic running;

    assign accept  = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign running = (state_reg == RUN);

    // -----------------------------------------------------------------------
    // Difference register: cleared on accept, otherwise only the slice
    // addressed by the counter is updated while running.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_d_slice
        always_comb begin
            d_next[gi*SLICE_W +: SLICE_W] = d_reg[gi*SLICE_W +: SLICE_W];
            if (accept) begin
                d_next[gi*SLICE_W +: SLICE_W] = '0;
            end else if (running && (cnt_reg == gi[1:0])) begin
                d_next[gi*SLICE_W +: SLICE_W] = slice_diff[SLICE_W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and control/flag logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        borrow_next = borrow_reg;
        bout_next   = bout_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next  = RUN;
                    cnt_next    = 2'd0;
                    a_next      = bus.a;
                    b_next      = bus.b;
                    borrow_next = bus.bin;
                    bout_next   = 1'b0;
                    ovf_next    = 1'b0;
                end else if (state_reg == DONE) begin
                    state_next  = IDLE;
                end
            end

            RUN: begin
                borrow_next = slice_borrow;
                cnt_next    = cnt_reg + 2'd1;
                if (cnt_reg == 2'(N_SLICES - 1)) begin
                    state_next = DONE;
                    bout_next  = slice_borrow;
                    // Signed overflow: operands of opposite sign and the
                    // result sign (top bit of the last slice) differs from a.
                    ovf_next   = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                                 (slice_diff[SLICE_W-1] ^ a_reg[WIDTH-1]);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state, so
        // they change on the same edge as the state itself.
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 2'd0;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            borrow_reg <= borrow_next;
            d_reg      <= d_next;
            bout_reg   <= bout_next;
            ovf_reg    <= ovf_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.d    = d_reg;
    assign bus.bout = bout_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_seq_sub_64.sv
// ---------------------------------------------------------------------------
// tb_seq_sub_64
//   Self-checking bench for seq_sub_64. The reference result is plain wide
//   arithmetic: a 65-bit unsigned difference gives d and the borrow-out, and
//   a 66-bit signed difference checked against the 64-bit signed range gives
//   the overflow flag.
// ---------------------------------------------------------------------------
module tb_seq_sub_64;

    logic clk;
    logic rst;

    seq_sub_64_if bus ();

    seq_sub_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    function automatic logic [65:0] ref_sub(input logic [63:0] ra,
                                            input logic [63:0] rb,
                                            input logic        rbin);
        logic [64:0]        ufull;
        logic signed [65:0] sfull;
        logic               rovf;
        ufull = {1'b0, ra} - {1'b0, rb} - {64'd0, rbin};
        sfull = $signed({ra[63], ra[63], ra}) - $signed({rb[63], rb[63], rb})
                - $signed({65'd0, rbin});
        rovf  = (sfull > $signed(66'h0_7FFF_FFFF_FFFF_FFFF)) ||
                (sfull < -$signed(66'h0_8000_0000_0000_0000));
        // {d, bout, ovf}
        return {ufull[63:0], ufull[64], rovf};
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Issue one operation and collect its result (no checking here).
    // Entered and left one time unit after a rising edge. On return the DUT
    // is in its done cycle, so a following call issues back-to-back.
    // poke=1 raises start for one cycle while the operation is running.
    // -----------------------------------------------------------------------
    task automatic run_op(input  logic [63:0] ta,
                          input  logic [63:0] tb_v,
                          input  logic        tbin,
                          input  bit          poke,
                          output logic [65:0] got,
                          output logic [65:0] got_at_accept,
                          output int          busy_cnt,
                          output int          lat);
        bit finished;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bin   = tbin;
        @(posedge clk);
        #1;
        got_at_accept = {bus.d, bus.bout, bus.ovf};
        bus.start = 1'b0;
        // Scramble the inputs: the operation in flight must not notice.
        bus.a     = {$urandom(), $urandom()};
        bus.b     = {$urandom(), $urandom()};
        bus.bin   = 1'($urandom_range(0, 1));
        busy_cnt  = 0;
        lat       = 0;
        finished  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            bus.start = (poke && lat == 1) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        if (!finished) lat = 999;
        got = {bus.d, bus.bout, bus.ovf};
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.d, bus.bout, bus.ovf, bus.busy, bus.done} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs: got d=%h bout=%b ovf=%b busy=%b done=%b, need all zero",
                     bus.d, bus.bout, bus.ovf, bus.busy, bus.done);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", bus.busy, bus.done);
        end
        $display("reset released");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_directed();
        logic [63:0] va   [6] = '{64'd31030099, 64'd420000021, 64'd0,
                                  64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000,
                                  64'h7FFF_FFFF_FFFF_FFFF};
        logic [63:0] vb   [6] = '{64'd12500002, 64'd500009800, 64'd0, 64'd1, 64'd1,
                                  64'hFFFF_FFFF_FFFF_FFFF};
        logic        vbin [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [63:0] ed   [6] = '{64'd18530096, 64'd18446744073629541837,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                                  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic        ebout[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [65:0] got, got0;
        int          bc, lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vbin[i], 1'b0, got, got0, bc, lat);
            $display("directed %0d: a=%h b=%h bin=%0b -> d=%h bout=%0b ovf=%0b lat=%0d busy=%0d",
                     i, va[i], vb[i], vbin[i], got[65:2], got[1], got[0], lat, bc);
            checks++;
            if (got !== {ed[i], ebout[i], eovf[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got d=%h bout=%b ovf=%b, need d=%h bout=%b ovf=%b",
                         i, got[65:2], got[1], got[0], ed[i], ebout[i], eovf[i]);
            end
            checks++;
            if (lat !== 4 || bc !== 4) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got done after %0d edges, busy %0d cycles, need 4 and 4",
                         i, lat, bc);
            end
            // One idle cycle: done drops, the result is held.
            @(posedge clk);
            #1;
            checks++;
            if ({bus.d, bus.bout, bus.ovf, bus.busy, bus.done} !==
                {ed[i], ebout[i], eovf[i], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL directed_hold[%0d]: got d=%h bout=%b ovf=%b busy=%b done=%b, need d=%h held, idle",
                         i, bus.d, bus.bout, bus.ovf, bus.busy, bus.done, ed[i]);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random();
        logic [63:0] ra, rb;
        logic        rbin;
        bit          poke;
        logic [65:0] got, got0, exp;
        int          bc, lat;
        for (int i = 0; i < 40; i++) begin
            ra   = pick_operand();
            rb   = pick_operand();
            rbin = 1'($urandom_range(0, 1));
            poke = 1'($urandom_range(0, 1));
            exp  = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, poke, got, got0, bc, lat);
            $display("random %0d: a=%h b=%h bin=%0b poke=%0b -> d=%h bout=%0b ovf=%0b",
                     i, ra, rb, rbin, poke, got[65:2], got[1], got[0]);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_result[%0d]: got d=%h bout=%b ovf=%b, need d=%h bout=%b ovf=%b",
                         i, got[65:2], got[1], got[0], exp[65:2], exp[1], exp[0]);
            end
            checks++;
            if (lat !== 4 || bc !== 4) begin
                errors++;
                $display("FAIL random_timing[%0d]: got done after %0d edges, busy %0d cycles, need 4 and 4",
                         i, lat, bc);
            end
            checks++;
            if (got0 !== 66'd0) begin
                errors++;
                $display("FAIL random_clear_on_accept[%0d]: got d=%h bout=%b ovf=%b, need zero",
                         i, got0[65:2], got0[1], got0[0]);
            end
        end
        // Leave the done cycle so the next test starts from idle.
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // start held high, operands changing every cycle: accepts land on every
    // fifth edge, each using the operands present at that edge.
    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [63:0] ha   [30];
        logic [63:0] hb   [30];
        logic        hbin [30];
        logic [65:0] exp;
        bus.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ha[c]   = pick_operand();
            hb[c]   = pick_operand();
            hbin[c] = 1'($urandom_range(0, 1));
            bus.a   = ha[c];
            bus.b   = hb[c];
            bus.bin = hbin[c];
            @(posedge clk);
            #1;
            checks++;
            if ({bus.busy, bus.done} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL b2b_status[%0d]: got busy=%b done=%b, need %s",
                         c, bus.busy, bus.done, (c % 5 == 4) ? "done" : "busy");
            end
            if (c % 5 == 4) begin
                exp = ref_sub(ha[c-4], hb[c-4], hbin[c-4]);
                $display("b2b op at edge %0d: a=%h b=%h bin=%0b -> d=%h bout=%0b ovf=%0b",
                         c - 4, ha[c-4], hb[c-4], hbin[c-4], bus.d, bus.bout, bus.ovf);
                checks++;
                if ({bus.d, bus.bout, bus.ovf} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got d=%h bout=%b ovf=%b, need d=%h bout=%b ovf=%b",
                             c, bus.d, bus.bout, bus.ovf, exp[65:2], exp[1], exp[0]);
                end
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_run();
        logic [65:0] got, got0;
        int          bc, lat;
        bus.start = 1'b1;
        bus.a     = 64'hFFFF_0000_1234_5678;
        bus.b     = 64'h0000_0001_0000_0001;
        bus.bin   = 1'b1;
        @(posedge clk);                // accept: RUN cycle 1 follows
        #1;
        bus.start = 1'b0;
        @(posedge clk);                // RUN cycle 2
        #1;
        @(posedge clk);                // RUN cycle 3
        #1;
        rst       = 1'b1;
        bus.start = 1'b1;              // reset must win over start
        @(posedge clk);
        #1;
        checks++;
        if ({bus.d, bus.bout, bus.ovf, bus.busy, bus.done} !== 68'd0) begin
            errors++;
            $display("FAIL mid_run_reset: got d=%h bout=%b ovf=%b busy=%b done=%b, need all zero",
                     bus.d, bus.bout, bus.ovf, bus.busy, bus.done);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_run_idle: got busy=%b done=%b, need idle", bus.busy, bus.done);
        end
        run_op(64'd5, 64'd3, 1'b0, 1'b0, got, got0, bc, lat);
        $display("after reset: a=5 b=3 bin=0 -> d=%h bout=%0b ovf=%0b", got[65:2], got[1], got[0]);
        checks++;
        if (got !== {64'd2, 1'b0, 1'b0} || lat !== 4) begin
            errors++;
            $display("FAIL post_reset_op: got d=%h bout=%b ovf=%b lat=%0d, need d=2 bout=0 ovf=0 lat=4",
                     got[65:2], got[1], got[0], lat);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_sub_64.md
# seq_sub_64

Multi-cycle 64-bit subtractor with borrow, the inverse companion to the team's combinational 64-bit full adder. It computes d = a − b − bin over four clock cycles, one 16-bit slice per cycle, with a registered slice-to-slice borrow. Operands are captured on a start/done handshake, so an upstream controller can issue back-to-back operations. It sits in the datapath alongside the adder as the ALU's subtract path.

## Interface
Parameters:
- none. Operand width is fixed at 64 and slice width at 16, giving 4 slices.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on the rising edge of clk
- a  input  64  minuend, unsigned or two's complement
- b  input  64  subtrahend
- bin  input  1  borrow-in
- d  output  64  difference, registered
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow
- busy  output  1  high while slices are being computed
- done  output  1  one-cycle pulse when d, bout and ovf are valid

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: computing slices; a 2-bit slice counter runs 0..3.
  - DONE: result valid.
- IDLE→RUN:
  - Condition: start=1 at an edge.
  - Action: latch a, b, bin into internal registers. Clear slice counter and partial d. Load the borrow register with bin.
- RUN, each edge:
  - Compute slice i = a[16i+15:16i] − b[16i+15:16i] − borrow.
  - Write the result to d[16i+15:16i] and store the slice's borrow-out in the borrow register.
  - Increment i.
- RUN→DONE: on the edge that computes slice 3. On that same edge:
  - bout = final borrow.
  - ovf = (a[63] ≠ b[63]) & (d[63] ≠ a[63]), using the latched operands.
- DONE→RUN if start=1; otherwise DONE→IDLE. Back-to-back operation is legal.
- start is ignored while in RUN. The latched operands are not disturbed.
- a, b and bin are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- Arithmetic is modulo 2^64, and wrap-around is expected:
  - An unsigned underflow sets bout.
  - A signed wrap sets ovf.
  - The two flags are independent.
- d, bout and ovf hold their last values until the next accepting edge. At that edge d is cleared and bout/ovf are cleared to 0.
- Reset is synchronous and active-high. In any state, including mid-RUN, the operation is aborted and there are no partial results.

## Timing
- Reset values: d=0, bout=0, ovf=0, busy=0, done=0, state=IDLE, counter=0, borrow register=0.
- Start accepted at edge k:
  - busy=1 after edges k through k+3.
  - Slices 0..3 are written at edges k+1..k+4.
  - After edge k+4: done=1 and busy=0, and d/bout/ovf are final.
  - done lasts exactly one cycle, the DONE state.
- Latency is 5 cycles from the accepting edge to done; issue interval is 5 cycles with back-to-back starts.
- busy and done are never high at the same time.
- When start is accepted from DONE, done falls and busy rises at the same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset takes priority over start at the same edge.

## Test plan
- Reset, then a=31030099, b=12500002, bin=1, start pulse → 5 cycles later done=1, d=18530096, bout=0, ovf=0. busy is high for exactly 4 cycles.
- a=420000021, b=500009800, bin=0 → d=18446744073629541837 (2^64 − 80009779), bout=1, ovf=0.
- a=0, b=0, bin=1 → d=0xFFFFFFFFFFFFFFFF, bout=1, ovf=0. Then a=0x0000000100000000, b=1, bin=0 → d=0x00000000FFFFFFFF, bout=0. This checks that the borrow ripples across slices 0→1→2.
- a=0x8000000000000000, b=1, bin=0 → d=0x7FFFFFFFFFFFFFFF, ovf=1, bout=0. Then a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF, bin=0 → d=0x8000000000000000, ovf=1, bout=1.
- Handshake case: start held high continuously with operands changing every cycle.
  - Required: operations complete every 5 cycles using the values present at each accepting edge.
  - Required: a change in a or b while busy does not alter d.
  - Required: a start pulse during RUN is ignored.
- Reset mid-operation: assert rst at the 3rd RUN cycle → next cycle d=0, bout=0, ovf=0, busy=0, done=0, state=IDLE. A subsequent start with a=5, b=3, bin=0 completes normally with d=2 and bout=0.
